// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: horizontal and vertical counters with registered
// syncs, active flags, pixel coordinates and line/frame strobes.
module vga_timing_gen #(
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int H_ACT    = 640,
  parameter int H_FP     = 16,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int V_ACT    = 480,
  parameter int V_FP     = 10,
  parameter int SYNC_POL = 0,
  parameter int CW       = 10
) (
  input  logic          clk25,
  input  logic          reset_n,
  input  logic          pix_en,
  output logic          hsync,
  output logic          vsync,
  output logic          hactive,
  output logic          vactive,
  output logic          de,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          line_start,
  output logic          frame_start
);

  localparam int H_TOTAL = H_SYNC + H_BP + H_ACT + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_ACT + V_FP;

  localparam logic [CW-1:0] ONE      = CW'(1);
  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_SYNC_E = CW'(H_SYNC);
  localparam logic [CW-1:0] V_SYNC_E = CW'(V_SYNC);
  localparam logic [CW-1:0] H_ACT_S  = CW'(H_SYNC + H_BP);
  localparam logic [CW-1:0] H_ACT_E  = CW'(H_SYNC + H_BP + H_ACT);
  localparam logic [CW-1:0] V_ACT_S  = CW'(V_SYNC + V_BP);
  localparam logic [CW-1:0] V_ACT_E  = CW'(V_SYNC + V_BP + V_ACT);
  localparam logic          POL      = (SYNC_POL != 0);

  logic [CW-1:0] h_cnt_q, h_cnt_d;
  logic [CW-1:0] v_cnt_q, v_cnt_d;
  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic          hact_q, hact_d;
  logic          vact_q, vact_d;
  logic          de_q, de_d;
  logic [CW-1:0] x_q, x_d;
  logic [CW-1:0] y_q, y_d;
  logic          line_q, line_d;
  logic          frame_q, frame_d;

  // Outputs are decoded from the next-state counts so they line up with the
  // position the counters hold after the same edge.
  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (pix_en) begin
      if (h_cnt_q == H_LAST) begin
        h_cnt_d = '0;
        v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + ONE;
      end else begin
        h_cnt_d = h_cnt_q + ONE;
      end
    end

    hsync_d = (h_cnt_d < H_SYNC_E) ? POL : ~POL;
    vsync_d = (v_cnt_d < V_SYNC_E) ? POL : ~POL;
    hact_d  = (h_cnt_d >= H_ACT_S) && (h_cnt_d < H_ACT_E);
    vact_d  = (v_cnt_d >= V_ACT_S) && (v_cnt_d < V_ACT_E);
    de_d    = hact_d && vact_d;
    x_d     = hact_d ? (h_cnt_d - H_ACT_S) : '0;
    y_d     = vact_d ? (v_cnt_d - V_ACT_S) : '0;
    // With pix_en high, h_cnt_d can only be 0 after a wrap.
    line_d  = pix_en && (h_cnt_d == '0);
    frame_d = line_d && (v_cnt_d == '0);
  end

  always_ff @(posedge clk25 or negedge reset_n) begin
    if (!reset_n) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
      hsync_q <= POL;
      vsync_q <= POL;
      hact_q  <= 1'b0;
      vact_q  <= 1'b0;
      de_q    <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      line_q  <= 1'b0;
      frame_q <= 1'b0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      hact_q  <= hact_d;
      vact_q  <= vact_d;
      de_q    <= de_d;
      x_q     <= x_d;
      y_q     <= y_d;
      line_q  <= line_d;
      frame_q <= frame_d;
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign hactive     = hact_q;
  assign vactive     = vact_q;
  assign de          = de_q;
  assign x           = x_q;
  assign y           = y_q;
  assign line_start  = line_q;
  assign frame_start = frame_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen: two small-raster builds (both sync
// polarities) and one default build, all checked against a pixel-index model.
module tb_vga_timing_gen;

  localparam int HS = 4, HB = 3, HA = 10, HF = 2;
  localparam int VS = 2, VB = 2, VA = 5,  VF = 1;
  localparam int NCYC = 6000;

  typedef struct {
    int hs; int vs; int ha; int va; int de; int ls; int fs; int x; int y;
  } obs_t;

  logic clk25 = 1'b0;
  logic reset_n;
  logic pix_en;

  always #5 clk25 = ~clk25;

  logic       a_hs, a_vs, a_ha, a_va, a_de, a_ls, a_fs;
  logic [5:0] a_x, a_y;
  logic       b_hs, b_vs, b_ha, b_va, b_de, b_ls, b_fs;
  logic [5:0] b_x, b_y;
  logic       c_hs, c_vs, c_ha, c_va, c_de, c_ls, c_fs;
  logic [9:0] c_x, c_y;

  vga_timing_gen #(.H_SYNC(HS), .H_BP(HB), .H_ACT(HA), .H_FP(HF),
                   .V_SYNC(VS), .V_BP(VB), .V_ACT(VA), .V_FP(VF),
                   .SYNC_POL(0), .CW(6)) u_small0 (
    .clk25(clk25), .reset_n(reset_n), .pix_en(pix_en),
    .hsync(a_hs), .vsync(a_vs), .hactive(a_ha), .vactive(a_va), .de(a_de),
    .x(a_x), .y(a_y), .line_start(a_ls), .frame_start(a_fs));

  vga_timing_gen #(.H_SYNC(HS), .H_BP(HB), .H_ACT(HA), .H_FP(HF),
                   .V_SYNC(VS), .V_BP(VB), .V_ACT(VA), .V_FP(VF),
                   .SYNC_POL(1), .CW(6)) u_small1 (
    .clk25(clk25), .reset_n(reset_n), .pix_en(pix_en),
    .hsync(b_hs), .vsync(b_vs), .hactive(b_ha), .vactive(b_va), .de(b_de),
    .x(b_x), .y(b_y), .line_start(b_ls), .frame_start(b_fs));

  vga_timing_gen u_default (
    .clk25(clk25), .reset_n(reset_n), .pix_en(pix_en),
    .hsync(c_hs), .vsync(c_vs), .hactive(c_ha), .vactive(c_va), .de(c_de),
    .x(c_x), .y(c_y), .line_start(c_ls), .frame_start(c_fs));

  obs_t q_a[$];
  obs_t q_b[$];
  obs_t q_c[$];
  int   checks = 0;
  int   errors = 0;

  // Reference: n = pix_en edges since reset; the raster position is simply
  // n modulo the frame size, split into line and column.
  function automatic obs_t model(int n, bit adv, int hs, int hb, int ha, int hf,
                                 int vs, int vb, int va, int vf, int pol);
    obs_t o;
    int ht = hs + hb + ha + hf;
    int vt = vs + vb + va + vf;
    int p  = n % (ht * vt);
    int h  = p % ht;
    int v  = p / ht;
    o.hs = (h < hs) ? pol : 1 - pol;
    o.vs = (v < vs) ? pol : 1 - pol;
    o.ha = (h >= hs + hb && h < hs + hb + ha) ? 1 : 0;
    o.va = (v >= vs + vb && v < vs + vb + va) ? 1 : 0;
    o.de = o.ha & o.va;
    o.x  = o.ha ? h - (hs + hb) : 0;
    o.y  = o.va ? v - (vs + vb) : 0;
    o.ls = (adv && h == 0) ? 1 : 0;
    o.fs = (adv && p == 0) ? 1 : 0;
    return o;
  endfunction

  function automatic logic [63:0] pack(obs_t o);
    return {o.hs[0], o.vs[0], o.ha[0], o.va[0], o.de[0], o.ls[0], o.fs[0],
            25'd0, o.x[15:0], o.y[15:0]};
  endfunction

  task automatic check(string name, obs_t got, obs_t exp);
    checks++;
    if (pack(got) !== pack(exp)) begin
      errors++;
      $display("FAIL %s t=%0t got hs%0d vs%0d ha%0d va%0d de%0d ls%0d fs%0d x%0d y%0d required hs%0d vs%0d ha%0d va%0d de%0d ls%0d fs%0d x%0d y%0d",
               name, $time, got.hs, got.vs, got.ha, got.va, got.de, got.ls, got.fs, got.x, got.y,
               exp.hs, exp.vs, exp.ha, exp.va, exp.de, exp.ls, exp.fs, exp.x, exp.y);
    end
  endtask

  // Monitor: the DUT presents a new raster position every cycle; compare at
  // the falling edge against the oldest queued expectation.
  initial begin
    obs_t g, e;
    forever begin
      @(negedge clk25);
      if (q_a.size() > 0) begin
        e = q_a.pop_front();
        g = '{int'(a_hs), int'(a_vs), int'(a_ha), int'(a_va), int'(a_de),
              int'(a_ls), int'(a_fs), int'(a_x), int'(a_y)};
        check("small_pol0", g, e);
      end
      if (q_b.size() > 0) begin
        e = q_b.pop_front();
        g = '{int'(b_hs), int'(b_vs), int'(b_ha), int'(b_va), int'(b_de),
              int'(b_ls), int'(b_fs), int'(b_x), int'(b_y)};
        check("small_pol1", g, e);
      end
      if (q_c.size() > 0) begin
        e = q_c.pop_front();
        g = '{int'(c_hs), int'(c_vs), int'(c_ha), int'(c_va), int'(c_de),
              int'(c_ls), int'(c_fs), int'(c_x), int'(c_y)};
        check("default", g, e);
      end
    end
  end

  // Stimulus: steady pix_en, then alternating, then random, with two
  // asynchronous mid-raster resets.
  initial begin
    int n;
    int rst_left;
    bit adv;
    n        = 0;
    rst_left = 0;
    reset_n  = 1'b0;
    pix_en   = 1'b0;
    for (int c = 0; c < NCYC; c++) begin
      @(posedge clk25);
      adv = reset_n && pix_en;
      if (adv) n++;
      #1;
      if (c == 2) reset_n = 1'b1;
      if (c == 1700 || c == 4123) begin
        reset_n  = 1'b0;
        n        = 0;
        adv      = 1'b0;
        rst_left = 1 + $urandom_range(0, 2);
      end else if (rst_left > 0) begin
        rst_left--;
        if (rst_left == 0) reset_n = 1'b1;
      end
      q_a.push_back(model(n, adv, HS, HB, HA, HF, VS, VB, VA, VF, 0));
      q_b.push_back(model(n, adv, HS, HB, HA, HF, VS, VB, VA, VF, 1));
      q_c.push_back(model(n, adv, 96, 48, 640, 16, 2, 33, 480, 10, 0));
      if (c < 1200)      pix_en = 1'b1;
      else if (c < 2600) pix_en = (c % 2 == 0);
      else               pix_en = ($urandom_range(0, 3) != 0);
    end
    @(negedge clk25);
    #1;
    checks++;
    if (q_a.size() + q_b.size() + q_c.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending required 0", q_a.size() + q_b.size() + q_c.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised VGA raster timing generator producing both horizontal and vertical timing from a single pixel clock.
- Successor to the horizontal-only generator: adds a vertical counter, configurable sync polarity, a pixel-enable input, and pixel coordinates, data-enable and line/frame strobes.
- Sits between the pixel clock source and the pixel/framebuffer pipeline, driving the VGA connector syncs.

Parameters:
- H_SYNC, 96, horizontal sync pulse length in pixels
- H_BP, 48, horizontal back porch in pixels
- H_ACT, 640, horizontal active pixels
- H_FP, 16, horizontal front porch in pixels
- V_SYNC, 2, vertical sync pulse length in lines
- V_BP, 33, vertical back porch in lines
- V_ACT, 480, vertical active lines
- V_FP, 10, vertical front porch in lines
- SYNC_POL, 0, level of hsync/vsync during the sync pulse (0 = active-low)
- CW, 10, width of counters and of x/y outputs

Ports:
- clk25  in  1  pixel clock
- reset_n  in  1  asynchronous active-low reset
- pix_en  in  1  advance raster by one pixel this cycle; tie to 1 for a 25 MHz pixel clock
- hsync  out  1  horizontal sync, SYNC_POL during pulse
- vsync  out  1  vertical sync, SYNC_POL during pulse
- hactive  out  1  horizontal active region
- vactive  out  1  vertical active region
- de  out  1  hactive AND vactive
- x  out  CW  active pixel column, 0..H_ACT-1; 0 outside active
- y  out  CW  active line, 0..V_ACT-1; 0 outside active
- line_start  out  1  one-cycle strobe when h_cnt enters 0
- frame_start  out  1  one-cycle strobe when (h_cnt, v_cnt) enters (0, 0)

Behaviour:
- Derived constants: H_TOTAL = H_SYNC+H_BP+H_ACT+H_FP (800) and V_TOTAL = V_SYNC+V_BP+V_ACT+V_FP (525).
- Segment order per line and per frame: sync, back porch, active, front porch. Count 0 is the first sync cycle.
- h_cnt counts 0..H_TOTAL-1 and wraps to 0.
- v_cnt increments only on the h_cnt wrap, counts 0..V_TOTAL-1 and wraps to 0 together with h_cnt.
- Counters advance only on clk25 edges with pix_en=1. With pix_en=0, counters and all level outputs hold, and both strobes are 0.
- All outputs are registered, computed from next-state counts, so they describe the same position the counters hold in that cycle. Latency from counter to outputs is 0 cycles.
- hsync = SYNC_POL when h_cnt < H_SYNC, else ~SYNC_POL. vsync likewise on v_cnt < V_SYNC.
- hactive = 1 when H_SYNC+H_BP <= h_cnt < H_SYNC+H_BP+H_ACT. vactive likewise on v_cnt.
- x = h_cnt-(H_SYNC+H_BP) when hactive, else 0. y likewise.
- All arithmetic is CW bits wide; H_TOTAL-1 and V_TOTAL-1 must fit in CW bits.
- line_start pulses on the pix_en cycle in which h_cnt becomes 0, including the cycle of the frame wrap.
- frame_start pulses on the pix_en cycle in which both counters become 0; line_start is also 1 in that cycle.
- Reset (asynchronous, any time, including mid-line): counters go to 0. Outputs take the values for position (0,0): hsync=vsync=SYNC_POL; hactive=vactive=de=0; x=y=0; line_start=frame_start=0.
- No strobe is issued for the reset position itself. The first frame_start occurs at the first wrap after reset.
- Release of reset_n is synchronous in effect: counting resumes on the first pix_en edge after release.

Test Plan:
- Reset, then pix_en=1 for 800 cycles -> hsync=0 for cycles 0-95 and 1 for cycles 96-799; hactive=1 for h_cnt 144..783 (640 cycles); line_start pulses exactly once, at cycle 800.
- Run one full frame of 420000 pix_en cycles -> frame_start exactly once, at cycle 420000; vsync=0 for lines 0-1 (1600 cycles); de=1 for exactly 307200 cycles.
- In line 35: first de cycle -> x=0, y=0; last de cycle -> x=639, y=0; line 514 last de cycle -> x=639, y=479; at h_cnt 784, x returns to 0.
- Drive pix_en toggling 1,0,1,0 -> counters advance every second cycle; one line takes 1600 clocks; strobes stay one clock wide and never occur on pix_en=0 cycles.
- SYNC_POL=1 build -> hsync and vsync are inverted versus the default; all other outputs are identical.
- Assert reset_n=0 at h_cnt=500, v_cnt=200 without a clock edge -> outputs go immediately to reset values; after release, hsync=0 for the next 96 pix_en cycles.
